// File: rtl/cpu_boot_pkg.sv
// Boot loader shared types: FSM state encoding, error codes, header count width.
// Latency: n/a. Backpressure: n/a.
// Imported by cpu_boot_loader; the CHECK state is only reachable with BOOT_CHECKSUM_EN.
package cpu_boot_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        HOLD  = 3'd3,
        RUN   = 3'd4,
        ERROR = 3'd5
    } boot_state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_LEN   = 2'd1;
    localparam logic [1:0] ERR_FRAME = 2'd2;
    localparam logic [1:0] ERR_CSUM  = 2'd3;

    // The header count needs one bit more than the address to express a full memory.
    function automatic int hdr_cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/cpu_boot_loader.sv
// Programs cpu imem from a header+payload word stream, then releases cpu_rst; optional BOOT_CHECKSUM_EN.
// Latency: imem write 1 cycle after accept; cpu_rst falls HOLD_CYCLES+1 edges after the final accept.
// Backpressure: in_ready is 1 only in IDLE/LOAD/CHECK and never stalls a legal beat.
module cpu_boot_loader
    import cpu_boot_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int BASE_ADDR   = 0,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int                CNT_W     = hdr_cnt_w(ADDR_W);
    localparam logic [CNT_W-1:0]  MAX_WORDS = CNT_W'(1) << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [7:0]        HOLD_INIT = 8'(HOLD_CYCLES);

    boot_state_t      state, state_nxt;
    logic [1:0]       err_nxt;
    logic [CNT_W-1:0] n_words;
    logic [7:0]       hold_cnt;
    logic             accept;
    logic             hdr_fire;
    logic             wr_fire;
    logic             last_pay;
    logic [CNT_W-1:0] hdr_n;

`ifdef BOOT_CHECKSUM_EN
    logic [31:0]      csum;
`endif

    assign in_ready = !rst && (state == IDLE || state == LOAD || state == CHECK);
    assign accept   = in_valid && in_ready;
    assign hdr_n    = in_data[CNT_W-1:0];
    assign last_pay = (words_loaded + CNT_W'(1)) == n_words;

    assign cpu_rst  = (state != RUN);
    assign done     = (state == RUN);
    assign error    = (state == ERROR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err_code;
        hdr_fire  = 1'b0;
        wr_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    hdr_fire = 1'b1;
                    if (hdr_n > MAX_WORDS) begin
                        state_nxt = ERROR;
                        err_nxt   = ERR_LEN;
                    end else if (hdr_n == '0) begin
`ifdef BOOT_CHECKSUM_EN
                        if (in_last) begin
                            state_nxt = ERROR;
                            err_nxt   = ERR_FRAME;
                        end else begin
                            state_nxt = CHECK;
                        end
`else
                        if (in_last) begin
                            state_nxt = HOLD;
                        end else begin
                            state_nxt = ERROR;
                            err_nxt   = ERR_FRAME;
                        end
`endif
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
`ifdef BOOT_CHECKSUM_EN
                    // The checksum word carries in_last, so every payload beat must not.
                    if (in_last) begin
                        state_nxt = ERROR;
                        err_nxt   = ERR_FRAME;
                    end else begin
                        wr_fire = 1'b1;
                        if (last_pay) begin
                            state_nxt = CHECK;
                        end
                    end
`else
                    if (in_last != last_pay) begin
                        state_nxt = ERROR;
                        err_nxt   = ERR_FRAME;
                    end else begin
                        wr_fire = 1'b1;
                        if (last_pay) begin
                            state_nxt = HOLD;
                        end
                    end
`endif
                end
            end
`ifdef BOOT_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    if (!in_last) begin
                        state_nxt = ERROR;
                        err_nxt   = ERR_FRAME;
                    end else if (in_data == csum) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = ERROR;
                        err_nxt   = ERR_CSUM;
                    end
                end
            end
`endif
            HOLD: begin
                if (hold_cnt == 8'd0) begin
                    state_nxt = RUN;
                end
            end
            RUN:     state_nxt = RUN;
            ERROR:   state_nxt = ERROR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            err_code     <= ERR_NONE;
            words_loaded <= '0;
            n_words      <= '0;
            hold_cnt     <= 8'd0;
        end else begin
            imem_we  <= wr_fire;
            err_code <= err_nxt;
            if (hdr_fire) begin
                n_words      <= hdr_n;
                words_loaded <= '0;
            end
            if (wr_fire) begin
                imem_addr    <= BASE + words_loaded[ADDR_W-1:0];
                imem_wdata   <= in_data;
                words_loaded <= words_loaded + CNT_W'(1);
            end
            // Counter is armed on HOLD entry and reaches zero HOLD_CYCLES edges later.
            if (state_nxt == HOLD && state != HOLD) begin
                hold_cnt <= HOLD_INIT;
            end else if (state == HOLD && hold_cnt != 8'd0) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
        end else if (hdr_fire) begin
            csum <= in_data;
        end else if (accept && state == LOAD) begin
            csum <= csum ^ in_data;
        end
    end
`endif

endmodule

// File: doc/cpu_boot_loader.md
Name: cpu_boot_loader

Overview:
- Upstream of the single-cycle MIPS cpu; owns the cpu reset line and programs the cpu's instruction memory write port from a 32-bit valid/ready word stream before letting the cpu run.
- Replaces bench-driven raw reset release: the cpu leaves reset only after a complete, well-formed program image is written and a programmable settle delay has expired.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity 2**ADDR_W words.
- BASE_ADDR, 0, first word address written; addresses wrap modulo 2**ADDR_W.
- HOLD_CYCLES, 4, cycles cpu_rst stays high after the last write; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  stream word valid.
- in_ready  out  1  stream word ready.
- in_data  in  32  stream word: header (word count N in bits [ADDR_W:0], upper bits ignored), then N payload words.
- in_last  in  1  marks final beat of image.
- imem_we  out  1  instruction memory write enable, one-cycle pulse per word.
- imem_addr  out  ADDR_W  instruction memory word address.
- imem_wdata  out  32  instruction word.
- cpu_rst  out  1  reset to cpu, active high.
- done  out  1  high while cpu is running.
- error  out  1  sticky image-format error.
- err_code  out  2  0 none, 1 length, 2 framing, 3 checksum.
- words_loaded  out  ADDR_W+1  payload words written so far.

Behaviour:
- One clock domain, clk; rst synchronous, active high. Reset values: state IDLE, cpu_rst=1, imem_we=0, imem_addr=0, imem_wdata=0, done=0, error=0, err_code=0, words_loaded=0. in_ready=0 while rst=1.
- Handshake: beat accepted on a rising edge where in_valid&&in_ready. in_ready is combinational from state: 1 in IDLE, LOAD (and CHECK); 0 elsewhere. in_valid gaps are legal. The block never stalls a legal beat.
- IDLE: accepted beat is the header. N=0 with in_last=1 goes to HOLD (run existing memory). N=0 with in_last=0 goes to ERROR code 2. N>2**ADDR_W goes to ERROR code 1. Otherwise latch N and clear the running index; go to LOAD.
- LOAD: each accepted beat registers imem_addr=BASE_ADDR+index (mod 2**ADDR_W) and imem_wdata=in_data. imem_we=1 for exactly the following cycle (latency 1), and words_loaded increments in the same cycle.
- LOAD framing: in_last must be 1 on the N-th beat and 0 on all earlier beats; any mismatch goes to ERROR code 2, and that beat is not written. After the N-th beat, go to HOLD (or CHECK with the optional feature).
- HOLD: counter loaded with HOLD_CYCLES and decremented each cycle; cpu_rst stays 1. cpu_rst falls, and done rises, exactly HOLD_CYCLES+1 rising edges after the edge accepting the final beat (or the header when N=0).
- RUN: cpu_rst=0, done=1, in_ready=0, input ignored. Only rst leaves RUN.
- ERROR: cpu_rst=1, error=1, err_code held, in_ready=0; only rst leaves ERROR.
- rst mid-operation: immediate return to reset values on the next edge. Memory contents already written remain. cpu_rst re-asserts the same edge; a fresh image then loads normally.

Optional Feature:
- Macro BOOT_CHECKSUM_EN.
- Defined: after the N-th payload beat (which must then have in_last=0), go to CHECK. CHECK accepts one checksum word with in_last=1, which must equal the XOR of the header and all payload words. Match goes to HOLD; mismatch goes to ERROR code 3; the checksum word is never written to memory. For N=0 the header is followed by a checksum word equal to the header.
- Undefined: no CHECK state, and err_code 3 is never produced.

Decomposition:
- Package cpu_boot_pkg holds:
  - the state encoding (IDLE, LOAD, CHECK, HOLD, RUN, ERROR);
  - the err_code constants ERR_NONE, ERR_LEN, ERR_FRAME, ERR_CSUM;
  - the header count field width helper.
- No sub-module: the hold counter and checksum accumulator are small enough to live inline.

Test Plan:
- Header 3, then 0x20080005, 0x20090007, 0x01095020, last on the third beat -> imem_we pulses at addr 0, 1, 2 with those data. words_loaded=3. cpu_rst falls 5 edges after the third accept. done=1.
- Header 3 with in_valid toggling every other cycle and BASE_ADDR=254 -> writes to 254, 255, 0. Same release timing relative to the final accept.
- Header 0 with in_last=1 -> no imem_we; cpu_rst falls 5 edges after the header accept.
- Header 300 (ADDR_W=8) -> error=1, err_code=1, cpu_rst stays 1, in_ready=0. Separately, header 3 with in_last on beat 2 -> err_code=2 and only one write.
- rst pulsed after the first payload word -> next edge: cpu_rst=1, words_loaded=0, state IDLE. A subsequent full 2-word image completes with done=1.
- BOOT_CHECKSUM_EN, header 2, words 0x1, 0x2, checksum 0x1 (=2^1^2) -> done=1. Repeat with checksum 0x0 -> err_code=3, cpu_rst stays 1.
